// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control sequencer.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    // Encoding is fixed so the register block can compare raw state codes.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Moore control FSM for the 1x3 router: decodes the header address, waits
// for the destination FIFO to drain, and drives the register-block strobes.
module router_fsm
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] dest;
    logic              hdr_valid;
    logic              hdr_empty;
    logic              dest_empty;
    logic              dest_soft_reset;

    // A header is only accepted for addresses 0..2.
    assign hdr_valid = pkt_valid && (data_in != INVALID_ADDR);

    // Emptiness of the FIFO addressed by the header currently on data_in.
    always_comb begin
        hdr_empty = 1'b0;
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    // Status of the latched destination; data_in carries payload after the header.
    always_comb begin
        dest_empty      = 1'b0;
        dest_soft_reset = 1'b0;
        case (dest)
            2'd0: begin
                dest_empty      = fifo_empty_0;
                dest_soft_reset = soft_reset_0;
            end
            2'd1: begin
                dest_empty      = fifo_empty_1;
                dest_soft_reset = soft_reset_1;
            end
            2'd2: begin
                dest_empty      = fifo_empty_2;
                dest_soft_reset = soft_reset_2;
            end
            default: begin
                dest_empty      = 1'b0;
                dest_soft_reset = 1'b0;
            end
        endcase
    end

    // State and destination registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
            dest  <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && hdr_valid)
                dest <= data_in;
        end
    end

    // Next-state logic; a soft reset on the active port overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_valid)
                    next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA:
                next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            LOAD_PARITY:
                next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (dest_empty)
                    next_state = LOAD_FIRST_DATA;
            end
            default:
                next_state = DECODE_ADDRESS;
        endcase
        if (state != DECODE_ADDRESS && dest_soft_reset)
            next_state = DECODE_ADDRESS;
    end

    // Moore output decode from the current state only.
    always_comb begin
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        case (state)
            DECODE_ADDRESS:     detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            default:            detect_add = 1'b1;
        endcase
    end

endmodule
